// File: rtl/lut_cfg_chain_loader.sv
// lut_cfg_chain_loader
// Writes one fractured-LUT6 configuration frame (64 SRAM bits + 1 mode bit)
// into the tile's configuration flip-flop chain. At the same time it captures
// the bits leaving the chain end, which gives a readback of the old contents.
//
// Ports:
//   prog_clk, pReset_n          programming clock, async active-low reset
//   cfg_valid/cfg_ready/cfg_data frame handshake (index 0..63 = sram, 64 = mode)
//   cfg_hold                    stall; gates ccff_shift_en while high
//   ccff_head/ccff_shift_en     serial data and shift enable into the chain
//   ccff_tail                   serial data out of the chain end
//   busy                        high while shifting or completing a frame
//   rb_valid/rb_data            one-cycle pulse with the previous chain contents
module lut_cfg_chain_loader #(
  parameter int unsigned CHAIN_LEN = 65,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                 prog_clk,
  input  logic                 pReset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [0:CHAIN_LEN-1] cfg_data,
  input  logic                 cfg_hold,
  output logic                 ccff_head,
  output logic                 ccff_shift_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 rb_valid,
  output logic [0:CHAIN_LEN-1] rb_data
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [0:CHAIN_LEN-1] sreg;

  // The highest index of the shift register is always the next bit to send.
  // It is zero outside SHIFT because the register is fully drained by then.
  assign ccff_head = sreg[CHAIN_LEN-1];

  // Handshake and shift enable are decoded straight from state.
  assign cfg_ready     = (state == S_IDLE);
  assign ccff_shift_en = (state == S_SHIFT) && !cfg_hold;

  // Frame sequencer, serializer and readback capture.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sreg     <= '0;
      rb_data  <= '0;
      busy     <= 1'b0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            sreg  <= cfg_data;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!cfg_hold) begin
            // The n-th bit leaving the chain came from FF CHAIN_LEN-1-n.
            rb_data[LAST - cnt] <= ccff_tail;
            sreg <= {1'b0, sreg[0:CHAIN_LEN-2]};
            if (cnt == LAST) begin
              rb_valid <= 1'b1;
              state    <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lut_cfg_chain_loader.md
Name: lut_cfg_chain_loader

Overview:
- Programming-side writer for the configuration-chain flip-flops that hold one fractured LUT6's configuration: 64 SRAM truth-table bits plus 1 mode bit.
- Accepts a parallel configuration frame over a valid/ready handshake.
- Serializes the frame into the chain on `ccff_head` with a per-bit shift enable.
- Simultaneously captures the bits emerging on `ccff_tail`, giving a readback of the previous chain contents.
- Sits between the bitstream loader and the LUT tile configuration chain.

Parameters:
- CHAIN_LEN, 65, number of chain flip-flops in one frame (64 SRAM bits plus 1 mode bit).
- CNT_W, 7, shift-counter width; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all state updates on its rising edge.
- pReset_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  frame offered.
- cfg_ready  output  1  loader can accept a frame.
- cfg_data  input  [0:CHAIN_LEN-1]  frame; index 0..63 = sram[0..63], index 64 = mode.
- cfg_hold  input  1  stall; freezes shifting while high.
- ccff_head  output  1  serial data into chain.
- ccff_shift_en  output  1  chain shifts at the next prog_clk edge when high.
- ccff_tail  input  1  serial data out of chain end.
- busy  output  1  high in SHIFT or DONE.
- rb_valid  output  1  one-cycle pulse; rb_data holds complete readback.
- rb_data  output  [0:CHAIN_LEN-1]  previous chain contents, same indexing as cfg_data.

Behaviour:
- Reset (pReset_n=0, asynchronous):
  - state=IDLE, counter=0, shift register=0, rb_data=0.
  - cfg_ready=1, ccff_head=0, ccff_shift_en=0, busy=0, rb_valid=0.
  - Reset mid-shift aborts immediately. Chain contents are then undefined, and the next accepted frame fully overwrites them.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready at edge T: latch cfg_data into the shift register, clear the counter, go to SHIFT.
- SHIFT:
  - cfg_ready=0, busy=1.
  - ccff_shift_en = !cfg_hold.
  - ccff_head = the current highest-index unsent bit. Bit CHAIN_LEN-1 (mode) is presented first and bit 0 last.
  - On each edge with ccff_shift_en=1:
    - Sample ccff_tail into the readback register at index CHAIN_LEN-1-counter.
    - Advance the shift register and increment the counter.
  - When the counter reaches CHAIN_LEN-1 and a shift occurs, go to DONE.
  - Result: exactly CHAIN_LEN shift-enabled cycles. After them, chain FF k (k=0 nearest ccff_head) holds cfg_data[k].
  - With no hold, ccff_shift_en is high in cycles T+1..T+CHAIN_LEN.
- cfg_hold:
  - Combinational gate on ccff_shift_en; no other effect.
  - While high in SHIFT: ccff_head keeps its value, counter and registers frozen. Hold of any length is legal.
  - Ignored in IDLE and DONE.
- DONE:
  - Lasts one cycle. rb_valid=1, busy=1, cfg_ready=0, ccff_shift_en=0, ccff_head=0.
  - Next state is IDLE.
  - Unstalled, rb_valid is high in cycle T+CHAIN_LEN+1 and cfg_ready returns in cycle T+CHAIN_LEN+2.
- rb_data:
  - Updates only in SHIFT; stable from DONE until the next frame's first shift.
  - Readback bit k = value chain FF k held before the load.
- ccff_head is 0 whenever not in SHIFT.
- cfg_valid while cfg_ready=0 is ignored; cfg_data is not sampled. The producer must hold its frame until accepted.
- Back-to-back loads: a frame offered during DONE is accepted in the first IDLE cycle, so there is one idle cycle between frames.
- The counter never wraps; it saturates logic-wise because SHIFT exits at CHAIN_LEN-1.
- All outputs are registered except ccff_shift_en and cfg_ready, which are decoded from state (ccff_shift_en also uses cfg_hold).

Test Plan:
- Bench model: a 65-FF chain model on ccff_head/ccff_tail, preloaded to all ones.
- Load, no hold:
  - Stimulus: load cfg_data = sram 0xDEADBEEF_0123CAFE (index 0 = MSB), mode=1.
  - Response: exactly 65 ccff_shift_en cycles in T+1..T+65; first ccff_head bit = 1 (mode); model chain FF k = cfg_data[k]; rb_valid at T+66; rb_data all ones; cfg_ready at T+67.
- Readback of prior frame:
  - Stimulus: second load of all zeros with mode=0 directly after the first.
  - Response: rb_data equals the first frame bit-for-bit; model chain all zero; one idle cycle between frames.
- Stall mid-shift:
  - Stimulus: cfg_hold high for 5 cycles after the 20th shift.
  - Response: ccff_shift_en low for those 5 cycles; ccff_head unchanged; total 65 shifts; rb_valid at T+71; final chain correct.
- Handshake:
  - Stimulus: cfg_valid held high with changing cfg_data during SHIFT.
  - Response: no acceptance (cfg_ready=0); only the frame present at T is loaded.
- Async reset:
  - Stimulus: pReset_n low after shift 30, asynchronous to prog_clk.
  - Response: all outputs at reset values immediately; rb_valid never pulses; a subsequent full load yields the correct chain and rb_data.
- Mode isolation:
  - Stimulus: frame with sram all zeros, mode=1.
  - Response: only the first serialized bit is 1; chain FF 64 = 1, all others 0.
